// File: rtl/llr_mem_ctrl_pkg.sv
// Shared types and code-size helpers for the LLR memory sequencing controller.
package llr_mem_ctrl_pkg;

  localparam int unsigned LLR_WORD_W = 64;

  localparam logic [1:0] CODE_N64     = 2'd0;
  localparam logic [1:0] CODE_N256    = 2'd1;
  localparam logic [1:0] CODE_N1024   = 2'd2;
  localparam logic [1:0] CODE_ILLEGAL = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SERVE,
    ST_ROTATE,
    ST_DONE
  } state_t;

  // Index of the final 64-bit word of a codeword (8 / 32 / 128 words).
  function automatic logic [6:0] last_word(input logic [1:0] code);
    case (code)
      CODE_N64:  return 7'd7;
      CODE_N256: return 7'd31;
      default:   return 7'd127;
    endcase
  endfunction

  // Index of the final 128-LLR block of a codeword (1 / 2 / 8 blocks).
  function automatic logic [2:0] last_blk(input logic [1:0] code);
    case (code)
      CODE_N64:  return 3'd0;
      CODE_N256: return 3'd1;
      default:   return 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/llr_mem_ctrl_if.sv
// Bundle of the controller's input stream, memory control and decoder hand-off signals.
interface llr_mem_ctrl_if #(
  parameter int unsigned WORD_W = llr_mem_ctrl_pkg::LLR_WORD_W
) ();
  logic              i_start;
  logic [1:0]        i_code;
  logic              i_in_valid;
  logic              o_in_ready;
  logic [WORD_W-1:0] i_in_data;
  logic              o_mem_wen;
  logic [WORD_W-1:0] o_mem_data;
  logic [1:0]        o_mem_code;
  logic              o_mem_rotate;
  logic              o_blk_valid;
  logic [2:0]        o_blk_idx;
  logic              i_blk_done;
  logic              o_busy;
  logic              o_done;
  logic              o_err;

  modport master (
    output i_start, i_code, i_in_valid, i_in_data, i_blk_done,
    input  o_in_ready, o_mem_wen, o_mem_data, o_mem_code, o_mem_rotate,
           o_blk_valid, o_blk_idx, o_busy, o_done, o_err
  );

  modport slave (
    input  i_start, i_code, i_in_valid, i_in_data, i_blk_done,
    output o_in_ready, o_mem_wen, o_mem_data, o_mem_code, o_mem_rotate,
           o_blk_valid, o_blk_idx, o_busy, o_done, o_err
  );
endinterface

// File: rtl/llr_mem_ctrl.sv
// Loads a codeword into the shift-write LLR memory, then serves it block by block.
// Optional LLR_MEM_CTRL_RESTORE_EN adds a final rotation returning memory to load order.
module llr_mem_ctrl
  import llr_mem_ctrl_pkg::*;
(
  input logic           i_clk,
  input logic           i_rst,
  llr_mem_ctrl_if.slave bus
);

  state_t     state_q, state_d;
  logic [6:0] word_cnt_q;
  logic [2:0] blk_idx_q;
  logic [1:0] code_q;
  logic       err_q;
  logic       start_ok;
  logic       in_hs;
  logic       last_blk_hit;

  assign start_ok     = bus.i_start && (bus.i_code != CODE_ILLEGAL);
  assign in_hs        = (state_q == ST_LOAD) && bus.i_in_valid;
  assign last_blk_hit = (blk_idx_q == last_blk(code_q));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      word_cnt_q <= '0;
      blk_idx_q  <= '0;
      code_q     <= CODE_ILLEGAL;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= bus.i_start && ((state_q != ST_IDLE) || (bus.i_code == CODE_ILLEGAL));
      case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            code_q     <= bus.i_code;
            word_cnt_q <= '0;
            blk_idx_q  <= '0;
          end
        end
        ST_LOAD:   if (in_hs) word_cnt_q <= word_cnt_q + 7'd1;
        // Rotation off the last block only happens on the restore pass; index wraps to 0.
        ST_ROTATE: blk_idx_q <= last_blk_hit ? '0 : blk_idx_q + 3'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_ok) state_d = ST_LOAD;
      ST_LOAD:   if (in_hs && (word_cnt_q == last_word(code_q))) state_d = ST_SERVE;
      ST_SERVE: begin
        if (bus.i_blk_done) begin
          if (!last_blk_hit) state_d = ST_ROTATE;
`ifdef LLR_MEM_CTRL_RESTORE_EN
          else if (code_q != CODE_N64) state_d = ST_ROTATE;
`endif
          else state_d = ST_DONE;
        end
      end
      ST_ROTATE: state_d = last_blk_hit ? ST_DONE : ST_SERVE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign bus.o_in_ready   = (state_q == ST_LOAD);
  assign bus.o_mem_wen    = in_hs;
  assign bus.o_mem_data   = (state_q == ST_LOAD) ? bus.i_in_data : '0;
  assign bus.o_mem_code   = code_q;
  assign bus.o_mem_rotate = (state_q == ST_ROTATE);
  assign bus.o_blk_valid  = (state_q == ST_SERVE);
  assign bus.o_blk_idx    = blk_idx_q;
  assign bus.o_busy       = (state_q != ST_IDLE);
  assign bus.o_done       = (state_q == ST_DONE);
  assign bus.o_err        = err_q;

endmodule

// File: tb/tb_llr_mem_ctrl.sv
// Self-checking bench for llr_mem_ctrl: randomized loads/serves against a codeword-level model.
module tb_llr_mem_ctrl;

`ifdef LLR_MEM_CTRL_RESTORE_EN
  localparam bit RESTORE = 1'b1;
`else
  localparam bit RESTORE = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [1:0] last_code;

  llr_mem_ctrl_if #(.WORD_W(64)) bus ();

  llr_mem_ctrl dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_start = 1'b0; bus.i_code = 2'd0; bus.i_in_valid = 1'b0;
    bus.i_in_data = '0; bus.i_blk_done = 1'b0;
    #2;
    checks++;
    if ({bus.o_in_ready, bus.o_mem_wen, bus.o_mem_rotate, bus.o_blk_valid, bus.o_busy,
         bus.o_done, bus.o_err, bus.o_mem_code, bus.o_blk_idx} !== 12'b0000000_11_000) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b wen=%b rot=%b bv=%b busy=%b done=%b err=%b code=%0d idx=%0d, expected all 0, code=3, idx=0",
               bus.o_in_ready, bus.o_mem_wen, bus.o_mem_rotate, bus.o_blk_valid, bus.o_busy,
               bus.o_done, bus.o_err, bus.o_mem_code, bus.o_blk_idx);
    end
    checks++;
    if (bus.o_mem_data !== 64'd0) begin
      errors++;
      $display("FAIL reset_mem_data: got %h expected 0", bus.o_mem_data);
    end
    step(); step();
    rst = 1'b0;
    last_code = 2'd3;
    step();
  endtask

  task automatic test_illegal();
    bus.i_code = 2'd3; bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    #1;
    checks++;
    if (bus.o_err !== 1'b1) begin
      errors++; $display("FAIL illegal_err: got %b expected 1", bus.o_err);
    end
    checks++;
    if ({bus.o_busy, bus.o_mem_wen, bus.o_mem_rotate, bus.o_in_ready, bus.o_blk_valid} !== 5'b0) begin
      errors++;
      $display("FAIL illegal_quiet: got busy=%b wen=%b rot=%b rdy=%b bv=%b expected all 0",
               bus.o_busy, bus.o_mem_wen, bus.o_mem_rotate, bus.o_in_ready, bus.o_blk_valid);
    end
    checks++;
    if (bus.o_mem_code !== last_code) begin
      errors++; $display("FAIL illegal_code_hold: got %0d expected %0d", bus.o_mem_code, last_code);
    end
    step();
    #1;
    checks++;
    if (bus.o_err !== 1'b0 || bus.o_busy !== 1'b0) begin
      errors++; $display("FAIL illegal_after: got err=%b busy=%b expected 0 0", bus.o_err, bus.o_busy);
    end
    step();
  endtask

  // Full codeword: start, load with random valid gaps, serve every block, check counts.
  task automatic run_codeword(input logic [1:0] code, input int gap_pct,
                              input int busy_start_at, input bit abort_in_rotate);
    int words, blocks, exp_rots, acc, wen_cnt, rot_cnt, budget, fin_idx;
    bit err_exp, fired;
    words    = 8 << (2 * int'(code));
    blocks   = (code == 2'd0) ? 1 : (code == 2'd1) ? 2 : 8;
    exp_rots = blocks - 1 + ((RESTORE && code != 2'd0) ? 1 : 0);
    fin_idx  = (RESTORE && code != 2'd0) ? 0 : blocks - 1;
    acc = 0; wen_cnt = 0; rot_cnt = 0; budget = 0; err_exp = 1'b0; fired = 1'b0;

    bus.i_code = code; bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;

    while (acc < words && budget < 4000) begin
      bus.i_in_valid = ($urandom_range(99) >= gap_pct);
      bus.i_in_data  = {$urandom, $urandom};
      bus.i_blk_done = $urandom_range(1);
      if (!fired && acc == busy_start_at) begin
        bus.i_start = 1'b1; bus.i_code = 2'($urandom_range(3)); fired = 1'b1;
      end
      #1;
      checks++;
      if (bus.o_in_ready !== 1'b1 || bus.o_mem_wen !== bus.i_in_valid) begin
        errors++;
        $display("FAIL load_hs word %0d: got rdy=%b wen=%b expected rdy=1 wen=%b",
                 acc, bus.o_in_ready, bus.o_mem_wen, bus.i_in_valid);
      end
      if (bus.i_in_valid) begin
        checks++;
        if (bus.o_mem_data !== bus.i_in_data) begin
          errors++;
          $display("FAIL load_data word %0d: got %h expected %h", acc, bus.o_mem_data, bus.i_in_data);
        end
      end
      checks++;
      if (bus.o_mem_rotate !== 1'b0 || bus.o_blk_valid !== 1'b0 || bus.o_busy !== 1'b1 ||
          bus.o_mem_code !== code) begin
        errors++;
        $display("FAIL load_state word %0d: got rot=%b bv=%b busy=%b code=%0d expected 0 0 1 %0d",
                 acc, bus.o_mem_rotate, bus.o_blk_valid, bus.o_busy, bus.o_mem_code, code);
      end
      checks++;
      if (bus.o_err !== err_exp) begin
        errors++; $display("FAIL load_err word %0d: got %b expected %b", acc, bus.o_err, err_exp);
      end
      if (bus.o_mem_wen === 1'b1) wen_cnt++;
      if (bus.i_in_valid) acc++;
      err_exp = bus.i_start;
      step();
      bus.i_start = 1'b0;
      bus.i_code  = code;
      budget++;
    end
    bus.i_in_valid = 1'b0; bus.i_blk_done = 1'b0;
    if (acc < words) begin
      errors++; $display("FAIL load_budget: got %0d words expected %0d", acc, words);
    end

    for (int b = 0; b < blocks; b++) begin
      repeat ($urandom_range(3)) begin
        bus.i_in_valid = $urandom_range(1);
        #1;
        checks++;
        if (bus.o_blk_valid !== 1'b1 || bus.o_blk_idx !== 3'(b) || bus.o_mem_wen !== 1'b0 ||
            bus.o_in_ready !== 1'b0 || bus.o_mem_rotate !== 1'b0 || bus.o_done !== 1'b0) begin
          errors++;
          $display("FAIL serve_wait blk %0d: got bv=%b idx=%0d wen=%b rdy=%b rot=%b done=%b expected 1 %0d 0 0 0 0",
                   b, bus.o_blk_valid, bus.o_blk_idx, bus.o_mem_wen, bus.o_in_ready,
                   bus.o_mem_rotate, bus.o_done, b);
        end
        step();
      end
      bus.i_blk_done = 1'b1; bus.i_in_valid = $urandom_range(1);
      #1;
      checks++;
      if (bus.o_blk_valid !== 1'b1 || bus.o_blk_idx !== 3'(b) || bus.o_mem_wen !== 1'b0) begin
        errors++;
        $display("FAIL serve_done blk %0d: got bv=%b idx=%0d wen=%b expected 1 %0d 0",
                 b, bus.o_blk_valid, bus.o_blk_idx, bus.o_mem_wen, b);
      end
      step();
      bus.i_blk_done = 1'b0; bus.i_in_valid = 1'b0;
      if (b < blocks - 1 || (RESTORE && code != 2'd0)) begin
        #1;
        checks++;
        if (bus.o_mem_rotate !== 1'b1 || bus.o_blk_valid !== 1'b0 || bus.o_mem_wen !== 1'b0 ||
            bus.o_blk_idx !== 3'(b)) begin
          errors++;
          $display("FAIL rotate blk %0d: got rot=%b bv=%b wen=%b idx=%0d expected 1 0 0 %0d",
                   b, bus.o_mem_rotate, bus.o_blk_valid, bus.o_mem_wen, bus.o_blk_idx, b);
        end
        if (bus.o_mem_rotate === 1'b1) rot_cnt++;
        if (abort_in_rotate) begin
          rst = 1'b1;
          #1;
          checks++;
          if ({bus.o_in_ready, bus.o_mem_wen, bus.o_mem_rotate, bus.o_blk_valid, bus.o_busy,
               bus.o_done, bus.o_err, bus.o_mem_code, bus.o_blk_idx} !== 12'b0000000_11_000 ||
              bus.o_mem_data !== 64'd0) begin
            errors++;
            $display("FAIL abort_reset: got rot=%b bv=%b busy=%b code=%0d idx=%0d expected 0 0 0 3 0",
                     bus.o_mem_rotate, bus.o_blk_valid, bus.o_busy, bus.o_mem_code, bus.o_blk_idx);
          end
          last_code = 2'd3;
          return;
        end
        step();
      end
    end

    #1;
    checks++;
    if (bus.o_done !== 1'b1 || bus.o_busy !== 1'b1 || bus.o_blk_valid !== 1'b0 ||
        bus.o_blk_idx !== 3'(fin_idx)) begin
      errors++;
      $display("FAIL done_pulse: got done=%b busy=%b bv=%b idx=%0d expected 1 1 0 %0d",
               bus.o_done, bus.o_busy, bus.o_blk_valid, bus.o_blk_idx, fin_idx);
    end
    step();
    #1;
    checks++;
    if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_mem_code !== code) begin
      errors++;
      $display("FAIL after_done: got done=%b busy=%b code=%0d expected 0 0 %0d",
               bus.o_done, bus.o_busy, bus.o_mem_code, code);
    end
    checks++;
    if (wen_cnt !== words) begin
      errors++; $display("FAIL wen_count: got %0d expected %0d", wen_cnt, words);
    end
    checks++;
    if (rot_cnt !== exp_rots) begin
      errors++; $display("FAIL rotate_count: got %0d expected %0d", rot_cnt, exp_rots);
    end
    last_code = code;
    step();
  endtask

  task automatic test_n64_back_to_back();
    run_codeword(2'd0, 0, -1, 1'b0);
  endtask

  task automatic test_n1024_gaps();
    run_codeword(2'd2, 30, -1, 1'b0);
  endtask

  task automatic test_start_while_busy();
    run_codeword(2'd1, 20, 5, 1'b0);
  endtask

  task automatic test_reset_in_rotate();
    run_codeword(2'd2, 10, -1, 1'b1);
    step();
    rst = 1'b0;
    step();
    run_codeword(2'd1, 0, -1, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_illegal();
    test_n64_back_to_back();
    test_n1024_gaps();
    test_start_while_busy();
    test_illegal();
    test_reset_in_rotate();
    run_codeword(2'd0, 40, -1, 1'b0);
    run_codeword(2'd2, 50, 100, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/llr_mem_ctrl.md
# llr_mem_ctrl

Sequencing controller for the 128-entry-window LLR memory. It accepts a stream of 64-bit LLR words over a valid/ready handshake and drives the memory's shift-write port until a full codeword (64/256/1024 LLRs) is loaded. It then presents the memory's front window to the decoder one block at a time, issuing one 128-rotation per block hand-off. It sits between the input interface and the decoder core, and is the only driver of the memory's write, rotate and code inputs.

## Interface
- `WORD_W`, 64: input word width (8 LLRs × 8 bits, sign-magnitude); the width of `i_in_data` and `o_mem_data`
- `i_clk`  in  1  clock
- `i_rst`  in  1  reset, asynchronous, active-high
- `i_start`  in  1  start pulse; samples `i_code`
- `i_code`  in  2  0 = N64, 1 = N256, 2 = N1024, 3 = illegal
- `i_in_valid`  in  1  input word valid
- `o_in_ready`  out  1  controller accepts a word
- `i_in_data`  in  WORD_W  input LLR word
- `o_mem_wen`  out  1  memory shift-write strobe
- `o_mem_data`  out  WORD_W  memory write data
- `o_mem_code`  out  2  latched code to the memory
- `o_mem_rotate`  out  1  memory rotate-by-128 strobe
- `o_blk_valid`  out  1  front window holds the current block
- `o_blk_idx`  out  3  index of the current block
- `i_blk_done`  in  1  decoder has finished the current block
- `o_busy`  out  1  controller is not in IDLE
- `o_done`  out  1  one-cycle pulse: codeword fully served
- `o_err`  out  1  one-cycle pulse: illegal start

## Operation
- FSM states: IDLE, LOAD, SERVE, ROTATE, DONE.
- IDLE:
  - `i_start` with code 0–2: latch the code into `o_mem_code`, clear the word and block counters, go to LOAD.
  - `i_start` with code 3: pulse `o_err`, stay in IDLE.
- LOAD:
  - `o_in_ready` = 1.
  - `o_mem_wen` = `i_in_valid & o_in_ready`, combinational.
  - `o_mem_data` = `i_in_data`, passed through.
  - Words per codeword: 8 / 32 / 128 for codes 0 / 1 / 2. The word counter is 7 bits.
  - On the handshake of the last word, go to SERVE.
- SERVE:
  - `o_blk_valid` = 1.
  - Blocks per codeword: 1 / 2 / 8.
  - On `i_blk_done`:
    - If this is not the last block: go to ROTATE.
    - If this is the last block: go to DONE.
- ROTATE: `o_mem_rotate` = 1 for exactly one cycle, `o_blk_idx` increments, return to SERVE.
- DONE: `o_done` = 1 for one cycle, then IDLE.
- `o_busy` = (state != IDLE).
- `i_start` while busy: ignored; pulse `o_err`.
- `i_blk_done` outside SERVE: ignored.
- `i_in_valid` outside LOAD: ignored; `o_in_ready` = 0.
- `o_mem_wen` and `o_mem_rotate` are never high in the same cycle.

## Timing
- Reset values:
  - state = IDLE.
  - `o_mem_code` = 2'd3, so the memory holds its contents.
  - `o_blk_idx` = 0.
  - All other outputs 0.
- Reset mid-operation returns to IDLE immediately. Memory contents are not cleared.
- LOAD accepts one word per cycle when `i_in_valid` stays high.
- N64 load takes exactly 8 cycles. SERVE is entered on the cycle after the last handshake.
- `o_blk_valid` is high in that first SERVE cycle; the memory has already absorbed the last word.
- Rotate at cycle t → memory updated at the t edge → SERVE with the new block at t+1.
- `o_blk_valid` is 0 during the ROTATE cycle.
- SERVE waits indefinitely for `i_blk_done`; there is no timeout.

## Configuration
- `LLR_MEM_CTRL_RESTORE_EN`:
  - Defined: `i_blk_done` on the last block of an N256 or N1024 codeword goes to ROTATE once more before DONE.
    - Total rotations equal the block count, so the memory returns to load order and the codeword can be re-served.
    - `o_blk_idx` wraps to 0 on this rotation.
    - N64 never rotates.
  - Undefined: the last block goes straight to DONE. Rotations = blocks − 1.

## Structure
- Package `llr_mem_ctrl_pkg`:
  - FSM state enum.
  - Code constants `CODE_N64` / `CODE_N256` / `CODE_N1024`.
  - Functions for words-per-code and blocks-per-code (last-word and last-block values).
- Single flat module. No sub-module is warranted.
- The memory itself is instantiated by the parent, not inside this block.

## Test plan
- Start, code 0; 8 back-to-back words → `o_mem_wen` high 8 cycles; `o_blk_valid` on the 9th cycle; `i_blk_done` → `o_done` pulse the next cycle; 0 rotations.
- Start, code 2; 128 words with random `i_in_valid` gaps → exactly 128 `o_mem_wen` pulses; 8 blocks served with `o_blk_idx` 0..7; 7 rotations (8 with `LLR_MEM_CTRL_RESTORE_EN`; final `o_blk_idx` = 0).
- Start, code 3 → `o_err` pulse; `o_busy` stays 0; no memory strobes.
- `i_start` during LOAD at word 5 of N256 → `o_err` pulse; load completes unaffected after 32 words.
- Assert `i_rst` during ROTATE of N1024 → all outputs at reset values in the same cycle; a new start with code 1 then serves 2 blocks correctly.
- `i_blk_done` during LOAD and `i_in_valid` during SERVE → no state change, no memory strobes.
